// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} seq_mul_state_t;

  function automatic int unsigned prod_width(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/seq_mul_shift_add_if.sv
// Start/busy/done handshake bundle plus operands and product for seq_mul_shift_add.
interface seq_mul_shift_add_if
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic                         start;
  logic                         abort;
  logic [WIDTH-1:0]             a;
  logic [WIDTH-1:0]             b;
  logic                         busy;
  logic                         done;
  logic [prod_width(WIDTH)-1:0] product;

  modport master (
    output start,
    output abort,
    output a,
    output b,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  abort,
    input  a,
    input  b,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/seq_mul_ctrl.sv
// FSM controller for the shift-add multiplier: IDLE -> CALC (until multiplier exhausted) -> DONE.
module seq_mul_ctrl
  import seq_mul_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic mplr_zero,
  output logic ld,
  output logic step,
  output logic ld_prod,
  output logic busy,
  output logic done
);

  seq_mul_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    step    = 1'b0;
    ld_prod = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ld      = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        // abort wins over both completion and stepping
        if (abort) begin
          state_d = IDLE;
        end else if (mplr_zero) begin
          ld_prod = 1'b1;
          state_d = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/seq_mul_shift_add.sv
// Sequential shift-add multiplier datapath; SEQ_MUL_SIGNED_EN selects two's-complement operands.
module seq_mul_shift_add
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_mul_shift_add_if.slave  bus
);

  localparam int unsigned ProdWidth = prod_width(WIDTH);

  logic [ProdWidth-1:0] mcand_q, mcand_d;
  logic [ProdWidth-1:0] acc_q, acc_d;
  logic [ProdWidth-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [ProdWidth-1:0] acc_final;
  logic                 ld, step, ld_prod, busy, done;

`ifdef SEQ_MUL_SIGNED_EN
  logic sign_q, sign_d;

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which still fits as unsigned W bits.
  assign a_mag     = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign b_mag     = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
  assign acc_final = sign_q ? (~acc_q + ProdWidth'(1)) : acc_q;

  always_comb begin
    sign_d = sign_q;
    if (ld) begin
      sign_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
    end
  end
`else
  assign a_mag     = bus.a;
  assign b_mag     = bus.b;
  assign acc_final = acc_q;
`endif

  seq_mul_ctrl u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (bus.start),
    .abort     (bus.abort),
    .mplr_zero (mplr_q == '0),
    .ld        (ld),
    .step      (step),
    .ld_prod   (ld_prod),
    .busy      (busy),
    .done      (done)
  );

  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    if (ld) begin
      mcand_d = {{WIDTH{1'b0}}, a_mag};
      mplr_d  = b_mag;
      acc_d   = '0;
    end else if (step) begin
      if (mplr_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
    end
    if (ld_prod) begin
      prod_d = acc_final;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = prod_q;

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Self-checking bench for seq_mul_shift_add (WIDTH=8): directed vectors plus a per-cycle model check.
module tb_seq_mul_shift_add;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  seq_mul_shift_add_if #(.WIDTH(W)) bus ();

  seq_mul_shift_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: what the product must be, and how many cycles after capture done rises.
  function automatic logic [2*W-1:0] mdl_prod(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
`ifdef SEQ_MUL_SIGNED_EN
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    p  = sx * sy;
`else
    p  = int'(x) * int'(y);
`endif
    return p[2*W-1:0];
  endfunction

  function automatic int mdl_lat(input logic [W-1:0] y);
    int v;
    int n;
`ifdef SEQ_MUL_SIGNED_EN
    v = int'($signed(y));
    if (v < 0) v = -v;
`else
    v = int'(y);
`endif
    n = 0;
    while (v > 0) begin
      v = v >> 1;
      n++;
    end
    return 1 + n;
  endfunction

  // Per-cycle model: an accepted op counts down its latency; done on reaching zero.
  bit             m_active = 1'b0;
  int             m_rem    = 0;
  logic [2*W-1:0] m_pend   = '0;
  logic [2*W-1:0] m_prod   = '0;

  initial begin
    logic           s_start, s_abort, s_rst;
    logic [W-1:0]   s_a, s_b;
    forever begin
      @(posedge clk);
      s_start = bus.start;
      s_abort = bus.abort;
      s_a     = bus.a;
      s_b     = bus.b;
      s_rst   = rst_n;
      #1;
      if (!s_rst) begin
        m_active = 1'b0;
        m_rem    = 0;
        m_prod   = '0;
      end else if (!m_active) begin
        if (s_start) begin
          m_active = 1'b1;
          m_rem    = mdl_lat(s_b);
          m_pend   = mdl_prod(s_a, s_b);
        end
      end else if (m_rem > 0) begin
        if (s_abort) begin
          m_active = 1'b0;
        end else begin
          m_rem--;
          if (m_rem == 0) m_prod = m_pend;
        end
      end else begin
        m_active = 1'b0;
      end
      check("cyc_busy", 64'(bus.busy), 64'(m_active));
      check("cyc_done", 64'(bus.done), 64'(m_active && (m_rem == 0)));
      check("cyc_product", 64'(bus.product), 64'(m_prod));
    end
  end

  task automatic wait_done(input string name, output int n);
    bit got;
    got = 1'b0;
    n   = 1;
    while (n <= 40 && !got) begin
      @(posedge clk);
      #1;
      if (bus.done) got = 1'b1;
      else n++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done want done within 40 cycles", name);
    end
    // Step out of DONE so the next start lands in IDLE (back-to-back).
    @(posedge clk);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp_p, input int exp_lat);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(name, n);
    check({name, "_lat"}, 64'(n), 64'(exp_lat));
    check({name, "_prod"}, 64'(bus.product), 64'(exp_p));
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_product", 64'(bus.product), 64'd0);

    check("mdl_13x11", 64'(mdl_prod(8'd13, 8'd11)), 64'h008F);
    check("mdl_lat_11", 64'(mdl_lat(8'd11)), 64'd5);
    check("mdl_lat_0", 64'(mdl_lat(8'd0)), 64'd1);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op("t1", 8'd13, 8'd11, 16'h008F, 5);
`ifdef SEQ_MUL_SIGNED_EN
    run_op("t2", 8'd255, 8'd255, 16'h0001, 2);
`else
    run_op("t2", 8'd255, 8'd255, 16'hFE01, 9);
`endif
    run_op("t3a", 8'd200, 8'd0, 16'h0000, 1);
    run_op("t3b", 8'd0, 8'd77, 16'h0000, 8);

    // Abort on the third CALC cycle; product keeps the previous result.
    run_op("t4pre", 8'd13, 8'd11, 16'h008F, 5);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd255;
    bus.b     = 8'd255;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("t4_busy", 64'(bus.busy), 64'd0);
    check("t4_done", 64'(bus.done), 64'd0);
    check("t4_product", 64'(bus.product), 64'h008F);
    run_op("t4post", 8'd3, 8'd4, 16'h000C, 4);

    // Start while busy is ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd7;
    bus.b     = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd1;
    bus.b     = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("t5", n);
    check("t5_product", 64'(bus.product), 64'h003F);
    repeat (2) @(negedge clk);
    check("t5_idle_busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-CALC clears outputs without a clock edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd5;
    bus.b     = 8'd6;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(bus.busy), 64'd0);
    check("t5_rst_done", 64'(bus.done), 64'd0);
    check("t5_rst_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("t5_after", 8'd2, 8'd3, 16'h0006, 3);

`ifdef SEQ_MUL_SIGNED_EN
    run_op("t6a", 8'hFD, 8'd5, 16'hFFF1, 4);
    run_op("t6b", 8'h80, 8'h80, 16'h4000, 9);
    run_op("t6c", 8'h7F, 8'h80, 16'hC080, 9);
    run_op("t6d", 8'hFF, 8'h00, 16'h0000, 1);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
